// File: rtl/nacid_pkg.sv
// ---------------------------------------------------------------------------
// nacid_pkg
// Shared definitions for the nucleic-acid array valve sequencer:
//   - state_e        : sequencer state codes (also driven on the debug port)
//   - valve_vec_t    : 13-bit vector of valve air lines, indexed by V_*
//   - OPEN_*         : per-state masks of valves that are open (1 = open)
//   - PUMP_PATTERN   : 3-phase peristaltic pattern {pump1,pump2,pump3}
// Valve air-line polarity on the outputs is 1 = pressurized = closed.
// The masks here are kept in "open" polarity so they read like the protocol.
// ---------------------------------------------------------------------------
package nacid_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_GUARD      = 4'd1,
        S_LYSIS_FILL = 4'd2,
        S_LOAD       = 4'd3,
        S_MIX        = 4'd4,
        S_TRAP       = 4'd5,
        S_WASH       = 4'd6,
        S_ELUTE      = 4'd7,
        S_DONE       = 4'd8
    } state_e;

    localparam int VALVE_W = 13;
    typedef logic [VALVE_W-1:0] valve_vec_t;

    localparam int V_LYSIS      = 0;
    localparam int V_WASH       = 1;
    localparam int V_ELUTE      = 2;
    localparam int V_HORIZ      = 3;
    localparam int V_VERTICAL   = 4;
    localparam int V_LOOP_EXIT  = 5;
    localparam int V_BEAD_VTL   = 6;
    localparam int V_BEAD_TRAP  = 7;
    localparam int V_COLLECTION = 8;
    localparam int V_WASTE      = 9;
    localparam int V_PUMP1      = 10;
    localparam int V_PUMP2      = 11;
    localparam int V_PUMP3      = 12;

    localparam valve_vec_t OPEN_NONE       = '0;
    localparam valve_vec_t OPEN_LYSIS_FILL = valve_vec_t'((1 << V_LYSIS) | (1 << V_VERTICAL));
    localparam valve_vec_t OPEN_LOAD       = valve_vec_t'(1 << V_HORIZ);
    localparam valve_vec_t OPEN_TRAP       = valve_vec_t'((1 << V_LOOP_EXIT) | (1 << V_BEAD_TRAP)
                                                          | (1 << V_WASTE));
    localparam valve_vec_t OPEN_WASH       = valve_vec_t'((1 << V_WASH) | (1 << V_VERTICAL)
                                                          | (1 << V_LOOP_EXIT) | (1 << V_BEAD_TRAP)
                                                          | (1 << V_WASTE));
    localparam valve_vec_t OPEN_ELUTE      = valve_vec_t'((1 << V_ELUTE) | (1 << V_VERTICAL)
                                                          | (1 << V_LOOP_EXIT) | (1 << V_BEAD_TRAP)
                                                          | (1 << V_COLLECTION));

    // Index 0 is the phase driven on MIX entry; {pump1,pump2,pump3}, 1 = closed.
    localparam logic [5:0][2:0] PUMP_PATTERN = {3'b001, 3'b011, 3'b010,
                                                3'b110, 3'b100, 3'b101};

    // Open set of the non-pump valves for a state. MIX opens only pump lines,
    // which are overlaid by the top level.
    function automatic valve_vec_t open_mask(input state_e s);
        case (s)
            S_LYSIS_FILL: open_mask = OPEN_LYSIS_FILL;
            S_LOAD:       open_mask = OPEN_LOAD;
            S_TRAP:       open_mask = OPEN_TRAP;
            S_WASH:       open_mask = OPEN_WASH;
            S_ELUTE:      open_mask = OPEN_ELUTE;
            default:      open_mask = OPEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/peristaltic_phase_gen.sv
// ---------------------------------------------------------------------------
// peristaltic_phase_gen
// Steps through the 6-entry peristaltic pattern, holding each entry for
// PHASE_CYCLES clocks while en is high.
//   clk, rst     : clock, synchronous active-high reset
//   en           : advance the pattern
//   clr          : return to phase 0, count 0 (dominates en)
//   pattern      : {pump1,pump2,pump3} for the current phase, 1 = closed
//   stroke_done  : high in the last clock of the last phase of a stroke
// ---------------------------------------------------------------------------
module peristaltic_phase_gen
    import nacid_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [2:0] pattern,
    output logic       stroke_done
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          phase_end;

    assign phase_end = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clr) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (en) begin
            if (phase_end) begin
                cnt_d = '0;
                idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign pattern     = PUMP_PATTERN[idx_q];
    assign stroke_done = phase_end && (idx_q == 3'd5);

endmodule

// File: rtl/nacid_valve_sequencer.sv
// ---------------------------------------------------------------------------
// nacid_valve_sequencer
// Runs one extraction protocol on the four-lane array:
//   LYSIS_FILL -> LOAD -> MIX -> TRAP -> WASH x wash_reps -> ELUTE -> DONE
// with an all-closed GUARD block before every step. Outputs are a Moore
// decode of the registered state (plus pump phase in MIX).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin protocol (only honoured in IDLE)
//   abort              : close everything, back to IDLE next clock
//   dwell_cycles       : fluid-step hold time (0 behaves as 1), latched on start
//   wash_reps          : number of WASH steps, latched on start
//   *_ctl, pump1..3    : valve air lines, 1 = pressurized = closed
//   busy               : not IDLE
//   done               : high for the single DONE cycle
//   state              : current state code (debug)
// Handshake: start is a level sampled on the clock edge while IDLE; a cycle
// with start=1, abort=0 in IDLE is the accepting edge. There is no ready
// back-pressure; busy=1 means further starts are ignored.
// ---------------------------------------------------------------------------
module nacid_valve_sequencer
    import nacid_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int MIX_STROKES  = 8,
    parameter int GUARD_CYCLES = 2,
    parameter int DWELL_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [2:0]         wash_reps,
    output logic               lysis_ctl,
    output logic               wash_ctl,
    output logic               elute_ctl,
    output logic               horiz_ctl,
    output logic               vertical_ctl,
    output logic               loop_exit_ctl,
    output logic               bead_vtl_ctl,
    output logic               bead_trap_ctl,
    output logic               collection_ctl,
    output logic               waste_ctl,
    output logic               pump1,
    output logic               pump2,
    output logic               pump3,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state
);

    localparam int SW = $clog2(MIX_STROKES + 1);
    localparam logic [SW-1:0]      STROKE_LAST = SW'(MIX_STROKES - 1);
    localparam logic [DWELL_W-1:0] GUARD_LAST  = DWELL_W'(GUARD_CYCLES - 1);

    state_e             state_q, state_d;
    state_e             next_q, next_d;      // destination after the current GUARD
    logic [DWELL_W-1:0] timer_q, timer_d;    // clocks spent in current state
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [2:0]         reps_q, reps_d;
    logic [2:0]         rep_q, rep_d;        // completed WASH steps
    logic [SW-1:0]      stroke_q, stroke_d;  // completed MIX strokes

    logic       accept, guard_end, dwell_end, mix_end, wash_last;
    logic [2:0] pump_pat;
    logic       stroke_done;
    valve_vec_t valve_closed;

    peristaltic_phase_gen #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_phase_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q == S_MIX),
        .clr         (state_q != S_MIX),
        .pattern     (pump_pat),
        .stroke_done (stroke_done)
    );

    assign accept    = (state_q == S_IDLE) && start && !abort;
    assign guard_end = (timer_q == GUARD_LAST);
    assign dwell_end = (timer_q == dwell_q - DWELL_W'(1));
    assign mix_end   = stroke_done && (stroke_q == STROKE_LAST);
    assign wash_last = ((rep_q + 3'd1) == reps_q);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_GUARD;
                    next_d  = S_LYSIS_FILL;
                end
            end
            S_GUARD: begin
                if (guard_end) state_d = next_q;
            end
            S_LYSIS_FILL: begin
                if (dwell_end) begin
                    state_d = S_GUARD;
                    next_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (dwell_end) begin
                    state_d = S_GUARD;
                    next_d  = S_MIX;
                end
            end
            S_MIX: begin
                if (mix_end) begin
                    state_d = S_GUARD;
                    next_d  = S_TRAP;
                end
            end
            S_TRAP: begin
                if (dwell_end) begin
                    state_d = S_GUARD;
                    next_d  = (reps_q == 3'd0) ? S_ELUTE : S_WASH;
                end
            end
            S_WASH: begin
                if (dwell_end) begin
                    state_d = S_GUARD;
                    next_d  = wash_last ? S_ELUTE : S_WASH;
                end
            end
            S_ELUTE: begin
                if (dwell_end) begin
                    state_d = S_GUARD;
                    next_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Counters and latched protocol parameters.
    always_comb begin
        dwell_d  = dwell_q;
        reps_d   = reps_q;
        rep_d    = rep_q;
        stroke_d = stroke_q;
        // Timer restarts on every state change, so it measures time-in-state.
        timer_d  = (state_d != state_q || state_q == S_IDLE) ? '0 : timer_q + DWELL_W'(1);

        if (accept) begin
            dwell_d = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
            reps_d  = wash_reps;
        end

        // rep_q must survive the GUARD between consecutive WASH steps.
        if (state_q == S_IDLE || state_q == S_TRAP) begin
            rep_d = '0;
        end else if (state_q == S_WASH && dwell_end) begin
            rep_d = rep_q + 3'd1;
        end

        if (state_q != S_MIX) begin
            stroke_d = '0;
        end else if (stroke_done) begin
            stroke_d = stroke_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            next_q   <= S_IDLE;
            timer_q  <= '0;
            dwell_q  <= '0;
            reps_q   <= '0;
            rep_q    <= '0;
            stroke_q <= '0;
        end else begin
            state_q  <= state_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
            dwell_q  <= dwell_d;
            reps_q   <= reps_d;
            rep_q    <= rep_d;
            stroke_q <= stroke_d;
        end
    end

    // Output decode: closed = not open; pumps follow the pattern only in MIX.
    always_comb begin
        valve_closed = ~open_mask(state_q);
        if (state_q == S_MIX) begin
            valve_closed[V_PUMP1] = pump_pat[2];
            valve_closed[V_PUMP2] = pump_pat[1];
            valve_closed[V_PUMP3] = pump_pat[0];
        end
    end

    assign lysis_ctl      = valve_closed[V_LYSIS];
    assign wash_ctl       = valve_closed[V_WASH];
    assign elute_ctl      = valve_closed[V_ELUTE];
    assign horiz_ctl      = valve_closed[V_HORIZ];
    assign vertical_ctl   = valve_closed[V_VERTICAL];
    assign loop_exit_ctl  = valve_closed[V_LOOP_EXIT];
    assign bead_vtl_ctl   = valve_closed[V_BEAD_VTL];
    assign bead_trap_ctl  = valve_closed[V_BEAD_TRAP];
    assign collection_ctl = valve_closed[V_COLLECTION];
    assign waste_ctl      = valve_closed[V_WASTE];
    assign pump1          = valve_closed[V_PUMP1];
    assign pump2          = valve_closed[V_PUMP2];
    assign pump3          = valve_closed[V_PUMP3];

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign state = state_q;

endmodule

// File: tb/tb_nacid_valve_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nacid_valve_sequencer
// Directed bench for the valve sequencer. Expected state/line traces are
// built per protocol from the documented step order and open sets, then
// compared cycle by cycle. A separate monitor checks break-before-make.
// Line vector order: {pump1,pump2,pump3,lysis,wash,elute,horiz,vertical,
//                     loop_exit,bead_vtl,bead_trap,collection,waste}.
// ---------------------------------------------------------------------------
module tb_nacid_valve_sequencer;
    import nacid_pkg::*;

    localparam int PHASE_CYCLES = 4;
    localparam int MIX_STROKES  = 8;
    localparam int GUARD_CYCLES = 2;
    localparam int DWELL_W      = 16;

    localparam logic [3:0] ST_IDLE  = S_IDLE;
    localparam logic [3:0] ST_GUARD = S_GUARD;
    localparam logic [3:0] ST_LYS   = S_LYSIS_FILL;
    localparam logic [3:0] ST_LOAD  = S_LOAD;
    localparam logic [3:0] ST_MIX   = S_MIX;
    localparam logic [3:0] ST_TRAP  = S_TRAP;
    localparam logic [3:0] ST_WASH  = S_WASH;
    localparam logic [3:0] ST_ELUTE = S_ELUTE;
    localparam logic [3:0] ST_DONE  = S_DONE;

    // clock / reset / DUT
    logic clk;
    logic rst, start, abort;
    logic [DWELL_W-1:0] dwell_cycles;
    logic [2:0] wash_reps;
    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl;
    logic bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl;
    logic pump1, pump2, pump3, busy, done;
    logic [3:0] state;
    logic [12:0] lines;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    nacid_valve_sequencer #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .MIX_STROKES  (MIX_STROKES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .DWELL_W      (DWELL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .dwell_cycles   (dwell_cycles),
        .wash_reps      (wash_reps),
        .lysis_ctl      (lysis_ctl),
        .wash_ctl       (wash_ctl),
        .elute_ctl      (elute_ctl),
        .horiz_ctl      (horiz_ctl),
        .vertical_ctl   (vertical_ctl),
        .loop_exit_ctl  (loop_exit_ctl),
        .bead_vtl_ctl   (bead_vtl_ctl),
        .bead_trap_ctl  (bead_trap_ctl),
        .collection_ctl (collection_ctl),
        .waste_ctl      (waste_ctl),
        .pump1          (pump1),
        .pump2          (pump2),
        .pump3          (pump3),
        .busy           (busy),
        .done           (done),
        .state          (state)
    );

    assign lines = {pump1, pump2, pump3, lysis_ctl, wash_ctl, elute_ctl, horiz_ctl,
                    vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl,
                    collection_ctl, waste_ctl};

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [3:0]  exp_state_q[$];
    logic [12:0] exp_lines_q[$];
    logic [2:0]  pat [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected lines from the open sets of each step (0 = open).
    function automatic logic [12:0] model_lines(input logic [3:0] st, input logic [2:0] pp);
        logic [12:0] v;
        v = 13'h1fff;
        case (st)
            ST_LYS:   begin v[9] = 1'b0; v[5] = 1'b0; end
            ST_LOAD:  v[6] = 1'b0;
            ST_MIX:   v[12:10] = pp;
            ST_TRAP:  begin v[4] = 1'b0; v[2] = 1'b0; v[0] = 1'b0; end
            ST_WASH:  begin v[8] = 1'b0; v[5] = 1'b0; v[4] = 1'b0; v[2] = 1'b0; v[0] = 1'b0; end
            ST_ELUTE: begin v[7] = 1'b0; v[5] = 1'b0; v[4] = 1'b0; v[2] = 1'b0; v[1] = 1'b0; end
            default:  v = 13'h1fff;
        endcase
        return v;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            exp_state_q.push_back(st);
            exp_lines_q.push_back(model_lines(st, 3'b111));
        end
    endtask

    task automatic push_mix();
        for (int s = 0; s < MIX_STROKES; s++)
            for (int p = 0; p < 6; p++)
                for (int c = 0; c < PHASE_CYCLES; c++) begin
                    exp_state_q.push_back(ST_MIX);
                    exp_lines_q.push_back(model_lines(ST_MIX, pat[p]));
                end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, state, ST_IDLE);
        chk({tag, "_lines"}, lines, 13'h1fff);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // Full protocol from IDLE; poke re-asserts start while busy.
    task automatic run_protocol(input int d, input int r, input bit poke);
        int n, dd, total_len, done_at, done_cnt, mix_cnt, wash_cnt;
        logic [3:0]  es;
        logic [12:0] el;
        dd = (d == 0) ? 1 : d;
        exp_state_q.delete();
        exp_lines_q.delete();
        push(ST_GUARD, GUARD_CYCLES); push(ST_LYS, dd);
        push(ST_GUARD, GUARD_CYCLES); push(ST_LOAD, dd);
        push(ST_GUARD, GUARD_CYCLES); push_mix();
        push(ST_GUARD, GUARD_CYCLES); push(ST_TRAP, dd);
        for (int k = 0; k < r; k++) begin
            push(ST_GUARD, GUARD_CYCLES); push(ST_WASH, dd);
        end
        push(ST_GUARD, GUARD_CYCLES); push(ST_ELUTE, dd);
        push(ST_GUARD, GUARD_CYCLES); push(ST_DONE, 1);
        n = exp_state_q.size();
        total_len = (6 + r) * GUARD_CYCLES + (4 + r) * dd + 192 + 1;
        done_at = 0; done_cnt = 0; mix_cnt = 0; wash_cnt = 0;

        dwell_cycles = DWELL_W'(d);
        wash_reps    = 3'(r);
        start        = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            es = exp_state_q.pop_front();
            el = exp_lines_q.pop_front();
            chk("trace_state", state, es);
            chk("trace_lines", lines, el);
            chk("trace_busy", busy, 1'b1);
            chk("trace_done", done, es == ST_DONE);
            if (done === 1'b1) begin done_cnt++; done_at = i + 1; end
            if (state === ST_MIX) mix_cnt++;
            if (state === ST_WASH) wash_cnt++;
            start = poke && (i == 4 || i == 149);
            if (i == 0) begin
                // Parameters are latched at start; later changes must not matter.
                dwell_cycles = DWELL_W'($urandom_range(0, 65535));
                wash_reps    = 3'($urandom_range(0, 7));
            end
        end
        start = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_at, total_len);
        chk("mix_len", mix_cnt, 192);
        chk("wash_len", wash_cnt, r * dd);
        tick();
        check_idle("post_run");
    endtask

    // Break-before-make monitor: two different open sets never touch, and
    // every open step follows at least GUARD_CYCLES all-closed clocks.
    logic [12:0] prev_id = '0;
    int closed_run = 100;
    always @(negedge clk) begin
        logic [12:0] open_v, id;
        open_v = ~lines;
        if (open_v[9:0] != 10'd0)        id = {3'b000, open_v[9:0]};
        else if (open_v[12:10] != 3'd0)  id = 13'h1000;
        else                             id = '0;
        if (rst === 1'b0) begin
            if (id != 13'd0 && prev_id != 13'd0) chk("bbm_same_step", id, prev_id);
            else if (id != 13'd0) chk("bbm_guard", closed_run >= GUARD_CYCLES, 1'b1);
        end
        closed_run = (id == 13'd0) ? closed_run + 1 : 0;
        prev_id = id;
    end

    initial begin
        int w;
        pat = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        rst = 1'b1; start = 1'b0; abort = 1'b0; dwell_cycles = '0; wash_reps = '0;
        tick();
        check_idle("in_reset");
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check_idle("reset_idle");

        // Main protocol, then the degenerate dwell=0 / no-wash case.
        run_protocol(3, 2, 1'b0);
        run_protocol(0, 0, 1'b0);

        // Abort in the second TRAP cycle.
        dwell_cycles = 16'd5; wash_reps = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (state !== ST_TRAP && w < 2000) begin
            tick();
            w++;
        end
        chk("reach_trap", state, ST_TRAP);
        chk("trap_lines", lines, model_lines(ST_TRAP, 3'b111));
        tick();
        chk("trap_second", state, ST_TRAP);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("after_abort");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", done, 1'b0);
            chk("abort_stays_idle", state, ST_IDLE);
        end
        run_protocol(2, 1, 1'b0);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        check_idle("start_abort");
        start = 1'b0; abort = 1'b0;
        tick();
        check_idle("start_abort_after");

        // Starts while busy are ignored.
        run_protocol(3, 1, 1'b1);

        // Reset mid-protocol behaves like abort.
        dwell_cycles = 16'd4; wash_reps = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_reset");
        tick();
        check_idle("mid_reset_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nacid_valve_sequencer.md
# nacid_valve_sequencer

Digital controller that drives the pneumatic control lines of the four-lane nucleic-acid processing array. It sequences one complete extraction protocol (lysis fill, sample load, peristaltic mixing, bead trap, repeated wash, elution to the collect ports) and produces the 3-phase peristaltic pattern for the shared on-chip pump. It sits between the host command logic and the off-chip solenoid manifold whose outputs feed the array's `*_ctl` and `pump1..3` lines.

## Interface
- `PHASE_CYCLES`, 4: clocks per peristaltic phase.
- `MIX_STROKES`, 8: full 6-phase pump strokes in MIX.
- `GUARD_CYCLES`, 2: all-closed clocks inserted before every step (break-before-make).
- `DWELL_W`, 16: width of the dwell counter.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin protocol; sampled only in IDLE.
- `abort`  in  1  force all-closed and return to IDLE.
- `dwell_cycles`  in  DWELL_W  per-fluid-step hold time; latched on accepted start.
- `wash_reps`  in  3  number of WASH steps; latched on accepted start.
- `lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl`  out  1 each  valve air lines; 1 = pressurized = closed.
- `pump1, pump2, pump3`  out  1 each  pump valve air lines; same polarity.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on protocol completion.
- `state`  out  4  current state code, for debug.

## Operation
- Moore FSM with a registered state. Valve outputs are a pure decode of the state plus the pump phase.
- States: IDLE, GUARD, LYSIS_FILL, LOAD, MIX, TRAP, WASH, ELUTE, DONE.
- Order: IDLE→LYSIS_FILL→LOAD→MIX→TRAP→WASH×wash_reps→ELUTE→DONE→IDLE. Every arrow except DONE→IDLE passes through GUARD, and a `next_step` register records the destination.
- Open valves per state (all others closed):
  - LYSIS_FILL: lysis, vertical.
  - LOAD: horiz.
  - MIX: pump only.
  - TRAP: loop_exit, bead_trap, waste.
  - WASH: wash, vertical, loop_exit, bead_trap, waste.
  - ELUTE: elute, vertical, loop_exit, bead_trap, collection.
  - bead_vtl is closed in every state.
- Pumps: `{pump1,pump2,pump3}` = 111 outside MIX. In MIX they cycle 101→100→110→010→011→001 and repeat, starting at 101 on entry.
- IDLE, GUARD and DONE drive all valves closed.
- `dwell_cycles` = 0 is treated as 1.
- `wash_reps` = 0 skips WASH, so TRAP is followed by GUARD and then ELUTE.
- `start` outside IDLE is ignored. `start` and `abort` in the same cycle: abort wins and the FSM stays in IDLE.
- `abort` in any state: IDLE on the next clock, all outputs closed, no `done` pulse.
- Reset: state IDLE, all valve and pump outputs 1, `busy`=0, `done`=0, `state`=0, counters 0. Reset mid-protocol behaves like abort.

## Timing
- `start` accepted at edge k: GUARD during cycles k+1 .. k+GUARD_CYCLES, LYSIS_FILL outputs from k+1+GUARD_CYCLES.
- Each fluid step is held exactly max(dwell_cycles,1) clocks.
- MIX lasts MIX_STROKES×6×PHASE_CYCLES clocks and exits after the last 001 phase completes.
- `done` is high for exactly the one DONE cycle; `busy` drops the cycle after.
- Total protocol length = 1 + 5 + wash_reps cycles of GUARD blocks (each GUARD_CYCLES long) + (4 + wash_reps)×dwell + MIX length + 1 (DONE).
- No output ever transitions directly from one open set to a different open set; at least GUARD_CYCLES all-closed clocks always separate them.

## Structure
- Shared package `nacid_pkg`:
  - state enum;
  - 13-bit valve-vector typedef with named bit indices;
  - per-state open-mask constants;
  - pump phase pattern array.
- Sub-module `peristaltic_phase_gen`:
  - inputs: `clk`, `rst`, `en`, `clr`;
  - outputs: 3-bit pattern and `stroke_done` pulse;
  - contains the phase-cycle counter and the 6-entry phase index.
- Top level holds the FSM, dwell counter, rep counter and stroke counter.

## Test plan
- Reset, then idle 10 cycles → all 13 lines = 1, `busy`=0, `done`=0.
- start, dwell=3, reps=2, defaults → state trace GUARD,LYSIS_FILL(3),…,WASH(3),GUARD,WASH(3),…,ELUTE(3),DONE. `done` is a single pulse at the computed total cycle count.
- MIX window with PHASE_CYCLES=4, MIX_STROKES=8 → 192 clocks, pattern 101,100,110,010,011,001 each held 4 clocks, and 111 before and after.
- reps=0, dwell=0 → WASH never entered, each fluid step lasts 1 clock.
- abort two cycles into TRAP → next cycle IDLE, all lines 1, no `done`; a subsequent start runs the full protocol.
- start asserted while busy, plus start and abort together in IDLE → both ignored. A checker confirms no cycle has open sets from two different steps.
